// File: rtl/quad_enc_speed_if.sv
// Encoder pins in, signed speed sample out; slave side belongs to quad_enc_speed.
interface quad_enc_speed_if #(
  parameter int N = 8
);
  logic                enc_a;
  logic                enc_b;
  logic signed [N-1:0] enc;
  logic                enc_valid;
  logic                err;

  modport master (output enc_a, output enc_b, input enc, input enc_valid, input err);
  modport slave  (input enc_a, input enc_b, output enc, output enc_valid, output err);
endinterface

// File: rtl/quad_enc_speed.sv
// x4 quadrature decoder with windowed, saturated signed speed output.
// Optional 3-sample glitch filter on each channel: define QENC_GLITCH_FILTER_EN.
module quad_enc_speed #(
  parameter int N      = 8,
  parameter int WINDOW = 75000
) (
  input logic             clk,
  input logic             rst,
  quad_enc_speed_if.slave bus
);

  localparam int ACC_W = 20;
  localparam int CNT_W = $clog2(WINDOW);
`ifdef QENC_GLITCH_FILTER_EN
  localparam int PRIME = 5;
`else
  localparam int PRIME = 3;
`endif
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO   = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[N-1:0];
    else if (v < SAT_LO) sat = SAT_LO[N-1:0];
    else                 sat = v[N-1:0];
  endfunction

  // channel pairs are {a, b}
  logic [1:0]              sync_p0, sync_p1, prev_p2, cur;
  logic [2:0]              prime_cnt;
  logic                    primed;
  logic signed [1:0]       step_d;
  logic                    ill_d;
  logic signed [1:0]       dlt_p2;
  logic                    ill_p2;
  logic                    err_r;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [N-1:0]     enc_r;
  logic                    vld_r;

`ifdef QENC_GLITCH_FILTER_EN
  logic [1:0] hist_p2, hist_p3, stable;
  // prev_p2 doubles as the filtered level: it only follows a bit after three equal samples
  assign stable = ~(sync_p1 ^ hist_p2) & ~(hist_p2 ^ hist_p3);
  assign cur    = (stable & sync_p1) | (~stable & prev_p2);
`else
  assign cur = sync_p1;
`endif

  assign primed = (prime_cnt == 3'(PRIME));

  always_comb begin
    step_d = 2'sb00;
    ill_d  = 1'b0;
    case ({prev_p2, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_d = 2'sb01;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_d = 2'sb11;
      4'b0011, 4'b0110, 4'b1001, 4'b1100: ill_d  = 1'b1;
      default: ;
    endcase
  end

  assign acc_nxt = acc + $signed({{(ACC_W-2){dlt_p2[1]}}, dlt_p2});

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      prev_p2   <= '0;
`ifdef QENC_GLITCH_FILTER_EN
      hist_p2   <= '0;
      hist_p3   <= '0;
`endif
      prime_cnt <= '0;
      dlt_p2    <= '0;
      ill_p2    <= 1'b0;
      err_r     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      enc_r     <= '0;
      vld_r     <= 1'b0;
    end else begin
      // sync stages
      sync_p0 <= {bus.enc_a, bus.enc_b};
      sync_p1 <= sync_p0;
      prev_p2 <= cur;
`ifdef QENC_GLITCH_FILTER_EN
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
`endif
      if (!primed) prime_cnt <= prime_cnt + 3'd1;

      // decode register
      dlt_p2 <= primed ? step_d : 2'sb00;
      ill_p2 <= primed & ill_d;
      err_r  <= ill_p2;

      // accumulate; the terminal cycle's delta closes into the published sample
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        acc   <= '0;
        enc_r <= sat(acc_nxt);
        vld_r <= 1'b1;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        acc   <= acc_nxt;
        vld_r <= 1'b0;
      end
    end
  end

  assign bus.enc       = enc_r;
  assign bus.enc_valid = vld_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_quad_enc_speed.sv
// Directed bench for quad_enc_speed: WINDOW=100 instance for counting, WINDOW=400 for saturation.
module tb_quad_enc_speed;
  localparam int N = 8;
`ifdef QENC_GLITCH_FILTER_EN
  localparam int LAT     = 5;
  localparam int SAT_GAP = 3;
`else
  localparam int LAT     = 3;
  localparam int SAT_GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  always #5 clk = ~clk;

  quad_enc_speed_if #(.N(N)) if100 ();
  quad_enc_speed_if #(.N(N)) if400 ();
  assign if100.enc_a = a;
  assign if100.enc_b = b;
  assign if400.enc_a = a;
  assign if400.enc_b = b;

  quad_enc_speed #(.N(N), .WINDOW(100)) u100 (.clk(clk), .rst(rst), .bus(if100));
  quad_enc_speed #(.N(N), .WINDOW(400)) u400 (.clk(clk), .rst(rst), .bus(if400));

  typedef struct {
    bit rev;
    int n_edges;
    int gap;
    int exp_enc;
  } vec_t;

  int cyc, checks, errors, idx;
  int err100 = 0;
  int err400 = 0;
  vec_t vecs[5];

  always @(negedge clk) begin
    if (if100.err === 1'b1) err100++;
    if (if400.err === 1'b1) err400++;
  end

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       gray = 2'b00;
      1:       gray = 2'b01;
      2:       gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic set_idx(input int i);
    idx = ((i % 4) + 4) % 4;
    {a, b} = gray(idx);
  endtask

  task automatic move(input bit rev);
    set_idx(rev ? idx - 1 : idx + 1);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_valid(input bit sel400, input int bound, output int c, output logic signed [63:0] v);
    bit found;
    found = 1'b0;
    c = -1;
    v = 0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      if ((sel400 ? if400.enc_valid : if100.enc_valid) === 1'b1) begin
        found = 1'b1;
        c = cyc;
        v = sel400 ? 64'($signed(if400.enc)) : 64'($signed(if100.enc));
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no enc_valid within %0d cycles, expected one", bound);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e0, e4;
    logic signed [63:0] v;
    bit got;

    vecs[0] = '{rev: 1'b0, n_edges: 10, gap: 5, exp_enc: 10};
    vecs[1] = '{rev: 1'b1, n_edges: 10, gap: 5, exp_enc: -10};
    vecs[2] = '{rev: 1'b0, n_edges: 0,  gap: 5, exp_enc: 0};
    vecs[3] = '{rev: 1'b0, n_edges: 3,  gap: 7, exp_enc: 3};
    vecs[4] = '{rev: 1'b1, n_edges: 20, gap: 4, exp_enc: -20};
    checks = 0;
    errors = 0;
    cyc = 0;
    set_idx(0);

    // reset state
    repeat (2) step();
    check("rst_enc100", $signed(if100.enc), 0);
    check("rst_vld100", if100.enc_valid, 0);
    check("rst_err100", if100.err, 0);
    check("rst_enc400", $signed(if400.enc), 0);
    check("rst_vld400", if400.enc_valid, 0);
    check("rst_err400", if400.err, 0);

    // table: edges inside window 1, then an empty window 2
    for (int t = 0; t < 5; t++) begin
      set_idx(0);
      do_reset();
      e0 = err100;
      repeat (2) step();
      for (int i = 0; i < vecs[t].n_edges; i++) begin
        move(vecs[t].rev);
        repeat (vecs[t].gap) step();
      end
      wait_valid(1'b0, 300, c, v);
      check($sformatf("vec%0d_cycle", t), c, 100);
      check($sformatf("vec%0d_enc", t), v, vecs[t].exp_enc);
      step();
      check($sformatf("vec%0d_vld_pulse", t), if100.enc_valid, 0);
      wait_valid(1'b0, 300, c, v);
      check($sformatf("vec%0d_next_cycle", t), c, 200);
      check($sformatf("vec%0d_next_enc", t), v, 0);
      check($sformatf("vec%0d_err", t), err100 - e0, 0);
    end

    // illegal 00->11 then three legal forward edges from 11
    set_idx(0);
    do_reset();
    e0 = err100;
    repeat (5) step();
    set_idx(2);
    for (int j = 0; j <= LAT + 1; j++) begin
      step();
      check($sformatf("err_at_k+%0d", j), if100.err, (j == LAT) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (5) step();
      move(1'b0);
    end
    wait_valid(1'b0, 300, c, v);
    check("ill_cycle", c, 100);
    check("ill_enc", v, 3);
    check("ill_err_count", err100 - e0, 1);

    // 2-cycle glitch on A nets to zero, a later legal edge still counts
    set_idx(0);
    do_reset();
    e0 = err100;
    repeat (10) step();
    a = 1'b1;
    repeat (2) step();
    a = 1'b0;
    repeat (10) step();
    move(1'b0);
    wait_valid(1'b0, 300, c, v);
    check("glitch_enc", v, 1);
    check("glitch_err", err100 - e0, 0);

    // edge whose acc update lands on the terminal cycle belongs to the closing window
    set_idx(0);
    do_reset();
    while (cyc < 100 - LAT - 1) step();
    move(1'b0);
    wait_valid(1'b0, 300, c, v);
    check("term_in_cycle", c, 100);
    check("term_in_enc", v, 1);
    wait_valid(1'b0, 300, c, v);
    check("term_in_next_enc", v, 0);

    // one cycle later it belongs to the next window
    set_idx(0);
    do_reset();
    while (cyc < 100 - LAT) step();
    move(1'b0);
    wait_valid(1'b0, 300, c, v);
    check("term_out_enc", v, 0);
    wait_valid(1'b0, 300, c, v);
    check("term_out_next_cycle", c, 200);
    check("term_out_next_enc", v, 1);

    // A=B=1 through reset, 5 edges, reset mid-window, only post-reset edges reported
    set_idx(2);
    do_reset();
    e0 = err100;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      move(1'b0);
      repeat (5) step();
    end
    repeat (10) step();
    rst = 1'b1;
    step();
    check("midrst_enc", $signed(if100.enc), 0);
    check("midrst_vld", if100.enc_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      repeat (5) step();
      move(1'b0);
    end
    wait_valid(1'b0, 300, c, v);
    check("midrst_cycle", c, 100);
    check("midrst_enc_after", v, 2);
    check("midrst_err", err100 - e0, 0);

    // saturation on the 400-cycle window, both directions
    for (int dir = 0; dir < 2; dir++) begin
      set_idx(0);
      do_reset();
      e0 = err100;
      e4 = err400;
      got = 1'b0;
      v = 0;
      c = -1;
      for (int i = 0; i < 400; i++) begin
        if (i % SAT_GAP == 0) move(dir[0]);
        step();
        if (if400.enc_valid === 1'b1 && !got) begin
          got = 1'b1;
          c = cyc;
          v = 64'($signed(if400.enc));
        end
      end
      check($sformatf("sat%0d_cycle", dir), c, 400);
      check($sformatf("sat%0d_enc", dir), v, (dir == 0) ? 127 : -128);
      check($sformatf("sat%0d_err", dir), (err100 - e0) + (err400 - e4), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_enc_speed.md
# quad_enc_speed

Quadrature encoder front end producing the signed per-interval speed sample `enc` consumed by the motor PID loop. Synchronizes the A/B channels and decodes them at x4 resolution. Accumulates signed edge counts over a fixed sampling window, then publishes a saturated N-bit speed word with a one-cycle valid strobe. The window matches the PID update interval: 75000 cycles, 1.5 ms at 50 MHz.

## Interface
- `N`, 8: width of `enc` output, two's complement.
- `WINDOW`, 75000: sampling window length in clk cycles. Legal range 4..524287.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enc_a`  input  1  encoder channel A, asynchronous.
- `enc_b`  input  1  encoder channel B, asynchronous.
- `enc`  output  N  signed edge count of the last completed window, saturated.
- `enc_valid`  output  1  one-cycle pulse when `enc` updates.
- `err`  output  1  one-cycle pulse on an illegal A/B transition.

## Operation
- Sync: each channel passes through 2 flops, then a third "previous" stage.
  - Decode compares the current pair {a,b} with the previous pair.
- Decode of previous→current, x4:
  - Forward, +1: 00→01, 01→11, 11→10, 10→00.
  - Reverse, −1: 00→10, 10→11, 11→01, 01→00.
  - No change: 0.
  - Both bits changed, illegal: delta 0 and `err` pulses.
- Accumulator: 20-bit signed. It cannot overflow, since there is at most ±1 per cycle and WINDOW ≤ 2^19−1.
- Window counter: 0..WINDOW−1, wraps to 0.
  - On the cycle it equals WINDOW−1, the terminal cycle:
    - `enc` ← saturate(acc + delta) to [−2^(N−1), 2^(N−1)−1]. With N=8 this is [−128, 127].
    - acc ← 0.
    - `enc_valid` ← 1 on the following cycle.
  - The delta of the terminal cycle belongs to the closing window, so no edge is lost or double-counted.
- Priming: a 3-cycle "primed" counter starts at reset release.
  - Decode output is forced to 0, with no `err`, until sync and previous stages all hold post-reset samples.
  - Inputs held at any static level during or after reset produce no count.
- `enc` holds its value between windows.
- `enc` is never cleared except by `rst`.

## Timing
- Reset values: `enc`=0, `enc_valid`=0, `err`=0, window counter=0, acc=0, sync/previous flops=0, primed=0.
- `rst` asserted mid-window aborts the window; the partial count is discarded.
- After reset release, the first `enc_valid` occurs WINDOW cycles later. It is registered: the terminal cycle is WINDOW−1, and the pulse is seen on the next edge.
- Pin-to-accumulator latency: a transition on `enc_a`/`enc_b` sampled at edge k changes acc at edge k+3.
  - With the filter enabled, latency is k+5.
- `err` is asserted at edge k+3 for one cycle per illegal transition, with the same latency rule.
- `enc` and `enc_valid` update on the same clock edge.
- `enc_valid` is high for exactly one cycle per window.
- Continuous operation has no dead cycles; each window spans exactly WINDOW cycles.

## Configuration
- `QENC_GLITCH_FILTER_EN` defined:
  - Each synchronized channel feeds a 3-sample stability filter.
  - The filtered level changes only after 3 consecutive identical samples differing from the current filtered level.
  - Pulses of 1–2 cycles are rejected.
  - Adds 2 cycles of latency; the priming count becomes 5.
- Not defined:
  - No filter; synchronized samples feed decode directly.
  - Single-cycle glitches decode as a forward step followed by a reverse step, or vice versa, giving net 0.

## Test plan
- WINDOW=100. Release reset, then apply 10 forward transitions spaced 5 cycles, all inside window 1 → `enc`=10 (0x0A) with one `enc_valid` pulse at cycle 100. The next window yields `enc`=0.
- Same stimulus in the reverse sequence → `enc`=−10 (0xF6).
- WINDOW=400, forward transition every cycle for the whole window → `enc`=127. Reverse every cycle → `enc`=−128 (0x80). No `err`.
- Force 00→11 in one sample → `err` high for exactly 1 cycle, 3 cycles later. The count is unchanged and the following legal edges count normally.
- Hold A=B=1 through reset, then count 5 forward edges, then assert `rst` mid-window → `enc`=0, `enc_valid`=0, no spurious count after release. The next window reports only post-reset edges.
- Place one forward edge so acc updates on the terminal cycle → it is counted in the closing window (`enc`=1), not the next one (`enc`=0). With the macro defined, a 2-cycle glitch on A is ignored and a 3-cycle pulse counts +1 then −1.
